// File: rtl/imm_ext_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_arbiter
// Description : Round-robin arbiter sharing one 16->32 immediate extender
//               between two requesters, with a single-entry output register.
//               Optional zero-extension select: define IMM_EXT_ZEXT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_arbiter #(
    parameter int RESET_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_imm16,
`ifdef IMM_EXT_ZEXT_EN
    input  logic        req0_zext,
`endif
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_imm16,
`ifdef IMM_EXT_ZEXT_EN
    input  logic        req1_zext,
`endif
    output logic        req1_ready,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [31:0] resp_imm32,
    input  logic        resp_ready
);

    localparam logic c_reset_ptr = (RESET_PRIO != 0);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_ptr;
    logic        r_resp_id;
    logic [31:0] r_resp_imm32;

    logic        w_resp_xfer;
    logic        w_can_accept;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_grant;
    logic [15:0] w_sel_imm;
    logic        w_sel_zext;
    logic [31:0] w_ext;

    assign w_resp_xfer  = (r_state == ST_FULL) && resp_ready;
    // Reset gating keeps the readies low even though the state is already EMPTY.
    assign w_can_accept = !rst && ((r_state == ST_EMPTY) || w_resp_xfer);
    assign w_grant0     = w_can_accept && req0_valid && (!req1_valid || !r_ptr);
    assign w_grant1     = w_can_accept && req1_valid && (!req0_valid ||  r_ptr);
    assign w_grant      = w_grant0 || w_grant1;

    assign w_sel_imm = w_grant1 ? req1_imm16 : req0_imm16;
`ifdef IMM_EXT_ZEXT_EN
    assign w_sel_zext = w_grant1 ? req1_zext : req0_zext;
`else
    assign w_sel_zext = 1'b0;
`endif
    assign w_ext = {(w_sel_zext ? 16'h0000 : {16{w_sel_imm[15]}}), w_sel_imm};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_EMPTY;
            r_ptr        <= c_reset_ptr;
            r_resp_id    <= 1'b0;
            r_resp_imm32 <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_grant) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_resp_xfer && !w_grant) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
            if (w_grant) begin
                r_resp_id    <= w_grant1;
                r_resp_imm32 <= w_ext;
                r_ptr        <= w_grant0;
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign resp_valid = (r_state == ST_FULL);
    assign resp_id    = r_resp_id;
    assign resp_imm32 = r_resp_imm32;

endmodule
`default_nettype wire
